// File: rtl/cache_pkg.sv
// Shared types and constants for the write-through cache and its write buffer.
// Address layout: tag 5 | index 1 | word offset 2 | byte offset 2.
package cache_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int BLK_LSB  = 4;
  localparam int WORD_LSB = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } wb_state_t;

  function automatic logic [ADDR_W-BLK_LSB-1:0] blk_addr(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:BLK_LSB];
  endfunction

endpackage

// File: rtl/wb_entry_array.sv
// Circular store of queued word writes: push/pop/coalesce and the parallel
// block-address compare against the cache's pending refill.
module wb_entry_array
  import cache_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  wb_entry_t         wr_entry,
  input  logic              head_locked,
  input  logic              pop,
  input  logic [ADDR_W-1:0] rd_addr,
  output wb_entry_t         head_entry,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              coal_head,
  output logic              rd_conflict
);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] newest_idx;
  logic             newest_is_head;
  logic             word_match;
  logic             accept;
  logic             coalesce;
  logic             push;
  logic             pop_ok;

  assign empty          = (count == '0);
  assign full           = (count == CNT_W'(DEPTH));
  assign newest_idx     = tail - PTR_W'(1);
  assign newest_is_head = (count == CNT_W'(1));
  assign word_match     = (entries[newest_idx].addr[ADDR_W-1:WORD_LSB] ==
                           wr_entry.addr[ADDR_W-1:WORD_LSB]);

  // Merging into the in-flight head would change data already on the memory bus.
  assign accept    = wr_req && !full;
  assign coalesce  = accept && !empty && word_match && !(newest_is_head && head_locked);
  assign push      = accept && !coalesce;
  assign coal_head = coalesce && newest_is_head;
  assign pop_ok    = pop && !empty;

  assign head_entry = entries[head];

  // NOTE: storage has no reset; an entry is valid only by its position within count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= wr_entry;
    end else if (coalesce) begin
      entries[newest_idx].data <= wr_entry.data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop_ok) head <= head + PTR_W'(1);
      if (push)   tail <= tail + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan from head so only the count valid slots take part, in-flight head included.
  always_comb begin
    rd_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) &&
          (blk_addr(entries[head + PTR_W'(i)].addr) == blk_addr(rd_addr))) begin
        rd_conflict = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Write buffer between the write-through cache and main memory: queues stores
// and drains them one at a time over a registered req/ack handshake.
module write_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_req,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_conflict,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_data,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  wb_state_t         state;
  wb_state_t         state_d;
  logic              mem_req_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_d;
  logic              pop;
  logic              coal_head;
  wb_entry_t         head_entry;

  assign wr_ready = !full;

  wb_entry_array #(.DEPTH(DEPTH)) u_entries (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_entry    ('{addr: wr_addr, data: wr_data}),
    .head_locked (state != IDLE),
    .pop         (pop),
    .rd_addr     (rd_addr),
    .head_entry  (head_entry),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .coal_head   (coal_head),
    .rd_conflict (rd_conflict)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    mem_data_d = mem_data;
    pop        = 1'b0;
    case (state)
      IDLE, GAP: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
        if (!empty) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = head_entry.addr;
          // A store merging into the head on this same edge must reach memory.
          mem_data_d = coal_head ? wr_data : head_entry.data;
        end
      end
      REQ: begin
        if (mem_ack) begin
          pop       = 1'b1;
          state_d   = GAP;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state    <= state_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      mem_data <= mem_data_d;
    end
  end

endmodule
